// File: rtl/univ_shift_register_pkg.sv
// Shared encodings for the universal shift register: command opcodes and FSM states.
// Both the top level and the single-step datapath import this package.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_ASHR = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the opcodes that run as a multi-cycle bit-stepping command.
    function automatic logic is_shift_op(input op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) ||
               (op == OP_ROTR) || (op == OP_ASHR);
    endfunction

endpackage

// File: rtl/univ_shift_register_shift_step.sv
// Combinational next register value for a single bit-step of a shift/rotate op.
// Non-shift opcodes pass the register through unchanged.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  op_t          op,
    input  logic         sin_l,
    input  logic         sin_r,
    output logic [N-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[N-2:0], sin_l};
            OP_SHR:  q_next = {sin_r, q[N-1:1]};
            OP_ROTL: q_next = {q[N-2:0], q[N-1]};
            OP_ROTR: q_next = {q[0], q[N-1:1]};
            OP_ASHR: q_next = {q[N-1], q[N-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_register.sv
// N-bit register executing one command at a time: load, hold, or a stepped
// shift/rotate of a programmable bit count, finishing with a one-cycle done pulse.
module univ_shift_register
    import univ_shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amount,
    input  logic [N-1:0]  I,
    input  logic          sin_l,
    input  logic          sin_r,
    input  logic          en,
    output logic [N-1:0]  Q,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done
);

    state_t        state_reg, state_next;
    op_t           op_reg, op_next;
    logic [AW-1:0] remaining_reg, remaining_next;
    logic [N-1:0]  q_reg, q_next;
    logic          done_reg, done_next;
    logic [N-1:0]  step_q;
    op_t           cmd_op;

    assign cmd_op = op_t'(op);

    shift_step #(.N(N)) u_shift_step (
        .q      (q_reg),
        .op     (op_reg),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_HOLD;
            remaining_reg <= '0;
            q_reg         <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            remaining_reg <= remaining_next;
            q_reg         <= q_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        remaining_next = remaining_reg;
        q_next         = q_reg;
        done_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_op == OP_LOAD) begin
                        q_next    = I;
                        done_next = 1'b1;
                    end else if (is_shift_op(cmd_op) && (amount != '0)) begin
                        // The accept edge only latches the command; stepping starts next edge.
                        op_next        = cmd_op;
                        remaining_next = amount;
                        state_next     = ST_RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    q_next         = step_q;
                    remaining_next = remaining_reg - AW'(1);
                    if (remaining_reg == AW'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Q      = q_reg;
    assign sout_l = q_reg[N-1];
    assign sout_r = q_reg[0];
    assign busy   = (state_reg == ST_RUN);
    assign done   = done_reg;

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register (N=8): directed scenarios plus
// randomized commands checked against an arithmetic reference model.
module tb_univ_shift_register;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amount;
    logic [N-1:0]  I;
    logic          sin_l;
    logic          sin_r;
    logic          en;
    logic [N-1:0]  Q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    exp_q = 8'h00;
    int            lat;

    univ_shift_register #(.N(N), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amount (amount),
        .I      (I),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .en     (en),
        .Q      (Q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
        check({tag, ".Q"}, 32'(Q), 32'(exp_q));
        check({tag, ".sout_l"}, 32'(sout_l), 32'(exp_q[7]));
        check({tag, ".sout_r"}, 32'(sout_r), 32'(exp_q[0]));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check({tag, ".done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one bit-step expressed as plain integer arithmetic on an 8-bit value.
    function automatic logic [7:0] ref_step(input int c_op, input logic [7:0] q, input bit sl, input bit sr);
        int v;
        v = int'(q);
        case (c_op)
            2: v = (v * 2 + int'(sl)) % 256;
            3: v = v / 2 + int'(sr) * 128;
            4: v = (v * 2) % 256 + v / 128;
            5: v = v / 2 + (v % 2) * 128;
            6: v = v / 2 + (v / 128) * 128;
            default: v = v;
        endcase
        return 8'(v);
    endfunction

    task automatic idle_tick();
        start = 1'b0;
        en    = 1'($urandom % 2);
        tick();
        check_all("idle", 1'b0, 1'b0);
    endtask

    // Issue one command and follow it to completion; lat_out = cycles from start to done.
    task automatic run_cmd(input logic [2:0] c_op, input logic [3:0] c_amt, input logic [7:0] c_data,
                           input bit rnd_en, input int stall_at, input int sin_fix,
                           input bit busy_start, output int lat_out);
        int  steps;
        int  cyc;
        int  stall_rem;
        bit  en_v;
        bit  sl;
        bit  sr;
        bit  shift_cmd;
        start  = 1'b1;
        op     = c_op;
        amount = c_amt;
        I      = c_data;
        en     = 1'($urandom % 2);
        sin_l  = 1'($urandom % 2);
        sin_r  = 1'($urandom % 2);
        tick();
        start = 1'b0;
        $display("cmd op=%0d amt=%0d data=%02h", c_op, c_amt, c_data);
        shift_cmd = (c_op >= 3'd2) && (c_op <= 3'd6);
        if (c_op == 3'd1) exp_q = c_data;
        if (!shift_cmd || c_amt == 4'd0) begin
            check_all("accept_imm", 1'b0, 1'b1);
            lat_out = 1;
            return;
        end
        check_all("accept_shift", 1'b1, 1'b0);
        steps     = 0;
        cyc       = 0;
        stall_rem = 2;
        while (steps < int'(c_amt) && cyc < int'(c_amt) * 8 + 20) begin
            en_v = 1'b1;
            if (steps == stall_at && stall_rem > 0) begin
                en_v = 1'b0;
                stall_rem--;
            end else if (rnd_en && cyc < int'(c_amt) * 4) begin
                en_v = ($urandom % 4) != 0;
            end
            sl = (sin_fix < 0) ? 1'($urandom % 2) : sin_fix[0];
            sr = (sin_fix < 0) ? 1'($urandom % 2) : sin_fix[0];
            start = 1'b0;
            if (busy_start && cyc == 0) begin
                start = 1'b1;
                op    = 3'd1;
                I     = 8'hFF;
            end else if (rnd_en && ($urandom % 3) == 0) begin
                start  = 1'b1;
                op     = 3'($urandom % 8);
                amount = 4'($urandom % 16);
                I      = 8'($urandom);
            end
            en    = en_v;
            sin_l = sl;
            sin_r = sr;
            tick();
            cyc++;
            if (en_v) begin
                exp_q = ref_step(int'(c_op), exp_q, sl, sr);
                steps++;
            end
            check_all("run", 1'(steps < int'(c_amt)), 1'(steps == int'(c_amt) && en_v));
            if (busy_start) check("never_ff", 32'(Q == 8'hFF), 32'd0);
        end
        start = 1'b0;
        if (steps < int'(c_amt)) check("timeout", 32'(steps), 32'(c_amt));
        lat_out = cyc + 1;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        amount = '0;
        I      = 8'h00;
        sin_l  = 1'b0;
        sin_r  = 1'b0;
        en     = 1'b0;
        #1;
        exp_q = 8'h00;
        check_all("reset", 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        idle_tick();

        // Reset while a SHL by 5 is running: abort with no done pulse.
        run_cmd(3'd1, 4'd0, 8'h5A, 1'b0, -1, -1, 1'b0, lat);
        start = 1'b1; op = 3'd2; amount = 4'd5; en = 1'b1;
        tick();
        start = 1'b0;
        check_all("mid_accept", 1'b1, 1'b0);
        sin_l = 1'b1;
        tick();
        exp_q = ref_step(2, exp_q, 1'b1, 1'b0);
        check_all("mid_step", 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 exp_q = 8'h00;
        check_all("mid_rst", 1'b0, 1'b0);
        tick();
        check_all("mid_rst_hold", 1'b0, 1'b0);
        rst = 1'b0;
        idle_tick();
        idle_tick();
        $display("reset mid-run done");

        // LOAD A5, then SHL by 3 with sin_l=1.
        run_cmd(3'd1, 4'd0, 8'hA5, 1'b0, -1, -1, 1'b0, lat);
        check("load_val", 32'(Q), 32'h000000A5);
        run_cmd(3'd2, 4'd3, 8'h00, 1'b0, -1, 1, 1'b0, lat);
        check("shl3_val", 32'(Q), 32'h0000002F);
        check("shl3_lat", 32'(lat), 32'd4);
        idle_tick();

        // ROTR by 9 on 81 with two stalled cycles mid-run.
        run_cmd(3'd1, 4'd0, 8'h81, 1'b0, -1, -1, 1'b0, lat);
        run_cmd(3'd5, 4'd9, 8'h00, 1'b0, 4, -1, 1'b0, lat);
        check("rotr9_val", 32'(Q), 32'h000000C0);
        check("rotr9_lat", 32'(lat), 32'd12);

        // ASHR by 2 on 90 with an ignored LOAD FF while busy.
        run_cmd(3'd1, 4'd0, 8'h90, 1'b0, -1, -1, 1'b0, lat);
        run_cmd(3'd6, 4'd2, 8'h00, 1'b0, -1, -1, 1'b1, lat);
        check("ashr2_val", 32'(Q), 32'h000000E4);

        // SHR by 0 on 3C, then a LOAD issued in the done cycle.
        run_cmd(3'd1, 4'd0, 8'h3C, 1'b0, -1, -1, 1'b0, lat);
        idle_tick();
        run_cmd(3'd3, 4'd0, 8'h00, 1'b0, -1, -1, 1'b0, lat);
        check("shr0_val", 32'(Q), 32'h0000003C);
        run_cmd(3'd1, 4'd0, 8'h6E, 1'b0, -1, -1, 1'b0, lat);
        check("load_in_done", 32'(Q), 32'h0000006E);
        idle_tick();

        // Randomized commands, including amounts beyond N and reserved/hold opcodes.
        for (int k = 0; k < 60; k++) begin
            run_cmd(3'($urandom % 8), 4'($urandom_range(0, 12)), 8'($urandom),
                    1'b1, -1, -1, 1'b0, lat);
            if (($urandom % 3) == 0) idle_tick();
        end
        idle_tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
- Parametrised successor to the single-load register. An N-bit register that accepts one command at a time: parallel load, hold, or a multi-cycle shift/rotate of a programmable bit count.
- A small FSM sequences one bit-step per enabled cycle and reports completion with a done pulse.
- Used as the serialiser/deserialiser and barrel-free shifter in the datapath.

Parameters:
- N, 8, register width in bits (N >= 2)
- AW, $clog2(N+1), width of the shift-amount field (can express 0..N)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  command strobe; accepted only when busy=0
- op  in  3  command opcode, sampled with start
- amount  in  AW  number of bit-steps for shift/rotate ops, sampled with start
- I  in  N  parallel load data, sampled with start when op=LOAD
- sin_l  in  1  serial bit entering at bit 0 on a left shift
- sin_r  in  1  serial bit entering at bit N-1 on a right shift
- en  in  1  step enable; when 0 a running shift stalls
- Q  out  N  register contents
- sout_l  out  1  Q[N-1], combinational from Q
- sout_r  out  1  Q[0], combinational from Q
- busy  out  1  high while a shift command is in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): Q=0, busy=0, done=0, state=IDLE, remaining counter=0. Reset mid-shift aborts with no done pulse.
- Opcodes:
  - 000 HOLD
  - 001 LOAD
  - 010 SHL (Q<={Q[N-2:0],sin_l})
  - 011 SHR (Q<={sin_r,Q[N-1:1]})
  - 100 ROTL
  - 101 ROTR
  - 110 ASHR (Q<={Q[N-1],Q[N-1:1]})
  - 111 reserved, treated as HOLD
- States: IDLE, RUN.
- IDLE, start=1:
  - HOLD/reserved: Q unchanged; done=1 in the next cycle.
  - LOAD: Q<=I at this edge, independent of en; done=1 in the next cycle.
  - Shift op with amount=0: Q unchanged; done=1 in the next cycle; stays IDLE.
  - Shift op with amount>=1: latch op; remaining<=amount; go to RUN; busy=1 from the next cycle. No step occurs on the accept edge.
- RUN:
  - Each edge with en=1 performs one step of the latched op and decrements remaining.
  - On the edge where remaining==1 and en=1: final step, go to IDLE, busy<=0, done<=1. Q's final value and done become visible in the same cycle.
  - en=0: Q and remaining hold; busy stays 1.
  - sin_l and sin_r are sampled on each step edge only.
- Latency: a shift by k with en constantly high gives done k+1 cycles after the start cycle. LOAD, HOLD and amount=0 give done 1 cycle after start.
- start while busy=1 is ignored, with no queueing. start in the same cycle that done is high is accepted (IDLE).
- amount > N is legal for all shift ops: executes exactly amount steps. SHL/SHR fully replace Q with serial-in bits; rotates wrap.
- done is registered, 1 cycle wide, and never asserted during reset.

Decomposition:
- Package univ_shift_pkg holds the op encodings (OP_HOLD … OP_ASHR) and the state encoding (ST_IDLE, ST_RUN).
- One sub-module, shift_step: purely combinational next value for one step, taking Q, op, sin_l and sin_r. The top level holds the FSM, the counter and the Q register.

Test Plan (N=8):
- Reset mid-RUN: rst pulse while busy=1 during SHL by 5 -> Q=00, busy=0, done never pulses; a new LOAD afterwards works.
- LOAD: start, op=LOAD, I=A5 -> Q=A5 on the next edge, done=1 for one cycle, busy stays 0.
- SHL by 3, sin_l=1, Q=A5 -> Q sequence 4B, 97, 2F; done coincides with Q=2F, 4 cycles after start; sout_l tracks Q[7].
- ROTR by 9 on Q=81, with en=0 for 2 cycles mid-run -> final Q=C0; busy is high for 11 cycles; done appears 12 cycles after start.
- ASHR by 2 on Q=90 -> Q=E4. A start issued while busy, with op=LOAD and I=FF, is ignored: Q is never FF.
- SHR with amount=0 on Q=3C -> Q stays 3C, done next cycle, busy never set. A LOAD start issued in that done cycle is accepted.
